instr_loader: RTL and testbench

Writer side of the instruction ROM image. Receives a byte stream over a valid/ready handshake and assembles little-endian DATA_WIDTH-bit words. Writes the words to the instruction memory write port at consecutive addresses from 0. Holds the core in reset via cpu_hold until the image is fully written, so the same memory can be loaded at run time instead of from a fixed .mem file.

---
 rtl/instr_loader.sv | 116 +++++++++++
 tb/tb_instr_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Instruction image loader: packs a little-endian byte stream into words, writes
// them to the instruction memory from address 0, and holds the core in reset until done.
module instr_loader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDRESS_WIDTH:0]   word_count_i,
  input  logic                     byte_valid_i,
  input  logic [7:0]               byte_data_i,
  output logic                     byte_ready_o,
  output logic                     wr_en_o,
  output logic [ADDRESS_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]    wr_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cpu_hold_o
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDRESS_WIDTH:0] MAX_WORDS = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH:0]   count_q, words_q;
  logic [ADDRESS_WIDTH:0]   count_d, words_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [BIDX_W-1:0]        bidx_q;
  logic                     wr_en_q, busy_q, done_q, hold_q;
  logic                     last_byte;

  always_comb begin
    count_d   = (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
    words_d   = words_q + 1'b1;
    last_byte = (bidx_q == BIDX_W'(BYTES - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      words_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bidx_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            count_q <= count_d;
            words_q <= '0;
            addr_q  <= '0;
            bidx_q  <= '0;
            // An empty image finishes immediately and releases the core.
            if (count_d == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_COLLECT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              hold_q  <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (byte_valid_i) begin
            data_q[{bidx_q, 3'b000} +: 8] <= byte_data_i;
            if (last_byte) begin
              bidx_q  <= '0;
              wr_en_q <= 1'b1;
              state_q <= S_WRITE;
            end else begin
              bidx_q <= bidx_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          words_q <= words_d;
          // Address stays on the last word so a full-memory load never wraps.
          if (words_d == count_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= S_COLLECT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready_o = (state_q == S_COLLECT);
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = addr_q;
  assign wr_data_o    = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cpu_hold_o   = hold_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every wr_en pulse.
module tb_instr_loader;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, byte_valid;
  logic [AW:0]   word_count;
  logic [7:0]    byte_data;
  logic          byte_ready, wr_en, busy, done, cpu_hold;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  instr_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .word_count_i(word_count),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .cpu_hold_o(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stim[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      exp_t e;
      n_wr++;
      chk("ready_low_in_write", 64'(byte_ready), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 64'(wr_addr), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("byte_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
  endtask

  // Reference: the image is the byte stream cut into little-endian words,
  // min(wc, 2**AW) of them, written to addresses 0,1,2,...
  task automatic run_load(input int wc, input int gap_at, input int pulse_at, input bit rnd_gaps);
    int n, base_wr, idx;
    logic [DW-1:0] w;
    logic [7:0] b;
    exp_t e;
    n = (wc > NWORDS) ? NWORDS : wc;
    base_wr = n_wr;
    start = 1'b1;
    word_count = (AW+1)'(wc);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk("empty_done", 64'(done), 64'd1);
      chk("empty_hold", 64'(cpu_hold), 64'd0);
      chk("empty_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("empty_no_write", 64'(n_wr - base_wr), 64'd0);
      return;
    end
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_hold", 64'(cpu_hold), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    idx = 0;
    for (int wi = 0; wi < n; wi++) begin
      w = '0;
      for (int k = 0; k < DW/8; k++) begin
        b = (idx < stim.size()) ? stim[idx] : 8'($urandom);
        w[8*k +: 8] = b;
        if (idx == gap_at) begin
          byte_valid = 1'b0;
          repeat (5) begin
            @(negedge clk);
            chk("gap_ready_high", 64'(byte_ready), 64'd1);
          end
        end else if (idx == pulse_at) begin
          byte_valid = 1'b0;
          start = 1'b1;
          word_count = (AW+1)'(1);
          @(negedge clk);
          start = 1'b0;
          chk("ignored_start_busy", 64'(busy), 64'd1);
        end else if (rnd_gaps && $urandom_range(3) == 0) begin
          byte_valid = 1'b0;
          repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        if (k == DW/8 - 1) begin
          e.addr = wi;
          e.data = w;
          exp_q.push_back(e);
        end
        send_byte(b);
        idx++;
      end
    end
    byte_valid = 1'b0;
    @(negedge clk);
    chk("load_done", 64'(done), 64'd1);
    chk("load_hold", 64'(cpu_hold), 64'd0);
    chk("load_busy", 64'(busy), 64'd0);
    chk("load_write_count", 64'(n_wr - base_wr), 64'(n));
    chk("load_queue_empty", 64'(exp_q.size()), 64'd0);
    stim.delete();
  endtask

  task automatic offer_in_done();
    int base_wr;
    base_wr = n_wr;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      chk("done_ready_low", 64'(byte_ready), 64'd0);
    end
    byte_valid = 1'b0;
    chk("done_held", 64'(done), 64'd1);
    chk("done_no_write", 64'(n_wr - base_wr), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // directed two-word image, continuous stream
    stim = '{8'h13, 8'h00, 8'h10, 8'h93, 8'hB3, 8'h00, 8'hB5, 8'h00};
    run_load(2, -1, -1, 1'b0);
    offer_in_done();

    // same image, valid dropped for 5 cycles after the 2nd byte
    stim = '{8'h13, 8'h00, 8'h10, 8'h93, 8'hB3, 8'h00, 8'hB5, 8'h00};
    run_load(2, 2, -1, 1'b0);

    // empty image
    run_load(0, -1, -1, 1'b0);

    // reset after 3 bytes of the first word
    start = 1'b1; word_count = (AW+1)'(2);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);
    run_load(1, -1, -1, 1'b0);

    // full memory, then an oversize count that must saturate
    run_load(256, -1, -1, 1'b0);
    offer_in_done();
    run_load(300, -1, -1, 1'b1);
    offer_in_done();

    // start pulsed mid-collect is ignored; restart from DONE overwrites addr 0
    run_load(2, -1, 1, 1'b0);
    run_load(1, -1, -1, 1'b0);

    for (int i = 0; i < 6; i++) run_load($urandom_range(6, 1), -1, -1, 1'b1);
    offer_in_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
